// File: rtl/clock_frec_meter.sv
// Gated frequency/period meter: counts synchronized rising edges of sig_in over a
// fixed clk_in window and reports the edge count and the last inter-edge period.
module clock_frec_meter #(
   parameter real FREC_IN      = 100.0,
   parameter int  GATE_US      = 10,
   parameter int  COUNT_WIDTH  = 16,
   parameter int  PERIOD_WIDTH = 16,
   parameter bit  CONTINUOUS   = 1'b0
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic                    sig_in,
   input  logic                    start,
   output logic                    busy,
   output logic                    valid,
   output logic [COUNT_WIDTH-1:0]  edge_count,
   output logic [PERIOD_WIDTH-1:0] period_cycles,
   output logic                    overflow
);

   localparam int GATE_RAW    = $rtoi(FREC_IN * GATE_US + 0.5);
   localparam int GATE_CYCLES = (GATE_RAW < 2) ? 2 : GATE_RAW;
   localparam int GW          = $clog2(GATE_CYCLES + 1);

   localparam logic [GW-1:0]           GATE_LAST  = GW'(GATE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0]  EDGE_MAX   = '1;
   localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

   typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

   state_t state, state_nxt;

   logic [2:0]              sync_q;
   logic                    rise;
   logic [GW-1:0]           gate_cnt, gate_nxt;
   logic [COUNT_WIDTH-1:0]  edge_cnt, edge_nxt;
   logic [PERIOD_WIDTH-1:0] per_cnt, per_cnt_nxt;
   logic [PERIOD_WIDTH-1:0] per_reg, per_reg_nxt;
   logic                    first_seen, first_nxt;
   logic                    ovf, ovf_nxt;
   logic                    clear, counting, gate_done;

   // Two flops resolve metastability; the third gives the previous level for edge detect.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[1:0], sig_in};
   end

   assign rise = sync_q[1] & ~sync_q[2];

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = GATE;
         GATE:    if (gate_cnt == GATE_LAST) state_nxt = DONE;
         DONE:    state_nxt = CONTINUOUS ? GATE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      valid = (state == DONE);
   end

   assign clear     = ((state == IDLE) && start) || ((state == DONE) && CONTINUOUS);
   assign counting  = (state == GATE);
   assign gate_done = counting && (gate_cnt == GATE_LAST);

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      gate_nxt    = gate_cnt;
      edge_nxt    = edge_cnt;
      per_cnt_nxt = per_cnt;
      per_reg_nxt = per_reg;
      first_nxt   = first_seen;
      ovf_nxt     = ovf;
      if (clear) begin
         gate_nxt    = '0;
         edge_nxt    = '0;
         per_cnt_nxt = '0;
         per_reg_nxt = '0;
         first_nxt   = 1'b0;
         ovf_nxt     = 1'b0;
      end else if (counting) begin
         gate_nxt = gate_cnt + GW'(1);
         if (rise) begin
            if (edge_cnt == EDGE_MAX) ovf_nxt  = 1'b1;
            else                      edge_nxt = edge_cnt + COUNT_WIDTH'(1);
            // Counter was reloaded to 1 on the previous rise, so it now holds the distance.
            if (first_seen) per_reg_nxt = per_cnt;
            per_cnt_nxt = PERIOD_WIDTH'(1);
            first_nxt   = 1'b1;
         end else if (first_seen) begin
            if (per_cnt == PERIOD_MAX) ovf_nxt     = 1'b1;
            else                       per_cnt_nxt = per_cnt + PERIOD_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         per_cnt    <= '0;
         per_reg    <= '0;
         first_seen <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         gate_cnt   <= gate_nxt;
         edge_cnt   <= edge_nxt;
         per_cnt    <= per_cnt_nxt;
         per_reg    <= per_reg_nxt;
         first_seen <= first_nxt;
         ovf        <= ovf_nxt;
      end
   end

   // Results load on entry to DONE (including a rise on the final gate cycle) and hold until the next one.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         edge_count    <= '0;
         period_cycles <= '0;
         overflow      <= 1'b0;
      end else if (gate_done) begin
         edge_count    <= edge_nxt;
         period_cycles <= per_reg_nxt;
         overflow      <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_clock_frec_meter.sv
// Bench for clock_frec_meter: table vectors, random square waves against an edge-list
// model, narrow-counter saturation, continuous mode and mid-gate reset.
module tb_clock_frec_meter;

   localparam int GATE = 1000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic sig_in = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

   logic        busy_a, valid_a, ovf_a;
   logic [15:0] edge_a, per_a;
   logic        busy_b, valid_b, ovf_b;
   logic [3:0]  edge_b;
   logic [15:0] per_b;
   logic        busy_c, valid_c, ovf_c;
   logic [15:0] edge_c, per_c;

   int n_run = 0;
   int n_fail = 0;
   int cyc = 0;
   int wave_t0 = 1 << 30;
   int wave_p = 2;
   int start_at_a = -1, start_at_b = -1;
   int start_at_c[3] = '{-1, -1, -1};

   clock_frec_meter dut_a (
      .clk_in(clk), .reset(reset), .sig_in(sig_in), .start(start_a),
      .busy(busy_a), .valid(valid_a), .edge_count(edge_a),
      .period_cycles(per_a), .overflow(ovf_a));

   clock_frec_meter #(.COUNT_WIDTH(4)) dut_b (
      .clk_in(clk), .reset(reset), .sig_in(sig_in), .start(start_b),
      .busy(busy_b), .valid(valid_b), .edge_count(edge_b),
      .period_cycles(per_b), .overflow(ovf_b));

   clock_frec_meter #(.CONTINUOUS(1'b1)) dut_c (
      .clk_in(clk), .reset(reset), .sig_in(sig_in), .start(start_c),
      .busy(busy_c), .valid(valid_c), .edge_count(edge_c),
      .period_cycles(per_c), .overflow(ovf_c));

   always #5 clk = ~clk;

   typedef struct {
      int p;
      int off;
      int exp_edges;
      int exp_period;
   } vec_t;

   task automatic check(input string name, input longint got, input longint exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // One cycle: inputs are driven at the falling edge and outputs read there too.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (cyc < wave_t0) sig_in = 1'b0;
      else               sig_in = ((cyc - wave_t0) % wave_p) < (wave_p / 2);
      start_a = (cyc == start_at_a);
      start_b = (cyc == start_at_b);
      start_c = (cyc == start_at_c[0]) || (cyc == start_at_c[1]) || (cyc == start_at_c[2]);
   endtask

   // Rising transition driven in cycle c is counted in cycle c+2; the gate spans
   // cycles s+1 .. s+GATE after the start cycle s.
   function automatic void model(input int p, input int off, output int n, output int per);
      int last, prev;
      n = 0; last = -1; prev = -1;
      for (int t = off + 2; t <= GATE; t += p) begin
         if (t >= 1) begin
            n++;
            prev = last;
            last = t;
         end
      end
      per = (n >= 2) ? last - prev : 0;
   endfunction

   task automatic measure(input string name, input int p, input int off,
                          input int exp_e, input int exp_p,
                          input bit use_b, input int exp_be, input int exp_bo);
      int s, lat_a, lat_b, re, rp, ro, rbe, rbp, rbo;
      s = cyc + 8;
      wave_p = p;
      wave_t0 = s + off;
      start_at_a = s;
      if (use_b) start_at_b = s;
      lat_a = -1; lat_b = -1;
      re = -1; rp = -1; ro = -1; rbe = -1; rbp = -1; rbo = -1;
      for (int i = 0; i < 1200 && (lat_a < 0 || (use_b && lat_b < 0)); i++) begin
         tick();
         if (cyc == s + 1) check({name, " busy in gate"}, busy_a, 1);
         if (valid_a && lat_a < 0) begin
            lat_a = cyc - s; re = edge_a; rp = per_a; ro = ovf_a;
         end
         if (use_b && valid_b && lat_b < 0) begin
            lat_b = cyc - s; rbe = edge_b; rbp = per_b; rbo = ovf_b;
         end
      end
      check({name, " latency"}, lat_a, GATE + 1);
      check({name, " edge_count"}, re, exp_e);
      check({name, " period_cycles"}, rp, exp_p);
      check({name, " overflow"}, ro, 0);
      if (use_b) begin
         check({name, " narrow latency"}, lat_b, GATE + 1);
         check({name, " narrow edge_count"}, rbe, exp_be);
         check({name, " narrow period_cycles"}, rbp, exp_p);
         check({name, " narrow overflow"}, rbo, exp_bo);
      end
      tick();
      check({name, " valid one cycle"}, valid_a, 0);
      check({name, " idle after done"}, busy_a, 0);
      check({name, " edge_count held"}, edge_a, exp_e);
   endtask

   initial begin
      vec_t vecs[9];
      int n_exp, p_exp, p, off, s, pulses, vseen;

      vecs[0] = '{p: 20,   off: 5,   exp_edges: 50,  exp_period: 20};
      vecs[1] = '{p: 4,    off: 0,   exp_edges: 250, exp_period: 4};
      vecs[2] = '{p: 7,    off: 3,   exp_edges: 143, exp_period: 7};
      vecs[3] = '{p: 333,  off: 10,  exp_edges: 3,   exp_period: 333};
      vecs[4] = '{p: 900,  off: 200, exp_edges: 1,   exp_period: 0};
      vecs[5] = '{p: 5000, off: 998, exp_edges: 1,   exp_period: 0};
      vecs[6] = '{p: 5000, off: 999, exp_edges: 0,   exp_period: 0};
      vecs[7] = '{p: 500,  off: -1,  exp_edges: 2,   exp_period: 500};
      vecs[8] = '{p: 500,  off: -2,  exp_edges: 2,   exp_period: 500};

      repeat (3) tick();
      check("reset busy", busy_a, 0);
      check("reset valid", valid_a, 0);
      check("reset edge_count", edge_a, 0);
      check("reset period_cycles", per_a, 0);
      check("reset overflow", ovf_a, 0);
      reset = 1'b1;
      repeat (5) tick();
      check("continuous stays idle after reset", busy_c, 0);

      // Constant sig_in: no edges at all.
      measure("const", 1 << 20, 1 << 20, 0, 0, 1'b0, 0, 0);

      for (int i = 0; i < 9; i++) begin
         measure($sformatf("vec%0d", i), vecs[i].p, vecs[i].off,
                 vecs[i].exp_edges, vecs[i].exp_period,
                 (i == 0), 15, 1);
      end

      for (int i = 0; i < 8; i++) begin
         p = int'($urandom_range(300, 4));
         off = int'($urandom_range(1003, 0)) - 3;
         model(p, off, n_exp, p_exp);
         measure($sformatf("rnd%0d p=%0d off=%0d", i, p, off), p, off, n_exp, p_exp, 1'b0, 0, 0);
      end

      // Continuous mode: one start, later starts while busy must not disturb the cadence.
      wave_p = 20;
      wave_t0 = cyc + 2;
      s = cyc + 10;
      start_at_c[0] = s;
      start_at_c[1] = s + 300;
      start_at_c[2] = s + GATE + 1;
      pulses = 0;
      for (int i = 0; i < 3 * (GATE + 1) + 20 && pulses < 3; i++) begin
         tick();
         if (valid_c) begin
            pulses++;
            check($sformatf("cont pulse%0d time", pulses), cyc - s, pulses * (GATE + 1));
            check($sformatf("cont pulse%0d edge_count", pulses), edge_c, 50);
            check($sformatf("cont pulse%0d period_cycles", pulses), per_c, 20);
            check($sformatf("cont pulse%0d overflow", pulses), ovf_c, 0);
         end
      end
      check("cont pulse count", pulses, 3);
      tick();
      check("cont rearmed busy", busy_c, 1);

      // Mid-gate reset: partial measurement dropped, outputs cleared at once.
      wave_p = 20;
      s = cyc + 8;
      wave_t0 = s + 5;
      start_at_a = s;
      while (cyc < s + 500) tick();
      check("pre-abort busy", busy_a, 1);
      reset = 1'b0;
      #1;
      check("abort busy", busy_a, 0);
      check("abort valid", valid_a, 0);
      check("abort edge_count", edge_a, 0);
      check("abort period_cycles", per_a, 0);
      check("abort overflow", ovf_a, 0);
      check("abort continuous busy", busy_c, 0);
      check("abort continuous edge_count", edge_c, 0);
      repeat (2) tick();
      reset = 1'b1;
      vseen = 0;
      for (int i = 0; i < GATE + 100; i++) begin
         tick();
         if (valid_a || busy_a || valid_c || busy_c) vseen++;
      end
      check("no activity after abort", vseen, 0);
      measure("after abort", 20, 5, 50, 20, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_frec_meter.md
CLOCK_FREC_METER -- requirements
Module: clock_frec_meter

Interface
REQ-001 SHALL have parameter FREC_IN, default 100.0, meaning clk_in frequency in MHz (real).
REQ-002 SHALL have parameter GATE_US, default 10, meaning gate window in microseconds (integer, >=1).
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, meaning width of edge_count.
REQ-004 SHALL have parameter PERIOD_WIDTH, default 16, meaning width of period_cycles.
REQ-005 SHALL have parameter CONTINUOUS, default 0, meaning 1 = re-arm automatically after each result.
REQ-006 SHALL have port clk_in  input  1  sole clock; all state on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port sig_in  input  1  asynchronous signal under measurement (e.g. a divided clock).
REQ-009 SHALL have port start  input  1  request one measurement; sampled only in IDLE.
REQ-010 SHALL have port busy  output  1  high while in GATE or DONE.
REQ-011 SHALL have port valid  output  1  one-cycle pulse when results update.
REQ-012 SHALL have port edge_count  output  COUNT_WIDTH  rising edges of sig_in seen in last gate.
REQ-013 SHALL have port period_cycles  output  PERIOD_WIDTH  clk_in cycles between last two rising edges in last gate.
REQ-014 SHALL have port overflow  output  1  a counter saturated during last gate.

Function
REQ-015 SHALL derive localparam GATE_CYCLES = round(FREC_IN*GATE_US), minimum 2, with gate counter width $clog2(GATE_CYCLES+1).
REQ-016 SHALL pass sig_in through a two-flop synchronizer, then a third flop; rise = stage2 & ~stage3. Edge is visible 3 clk_in edges after the sig_in transition.
REQ-017 SHALL implement FSM states IDLE, GATE, DONE.
REQ-018 In IDLE with start=1: SHALL go to GATE and clear gate counter, edge counter, period counter, first-edge flag and overflow flag. In IDLE with start=0: SHALL stay in IDLE.
REQ-019 In GATE: gate counter SHALL increment every cycle. When it equals GATE_CYCLES-1, SHALL go to DONE; a rise on that final cycle is still counted.
REQ-020 In GATE, on rise: edge counter SHALL increment, saturating at 2^COUNT_WIDTH-1; saturation sets overflow.
REQ-021 Period counter SHALL increment every GATE cycle after the first rise, saturating at 2^PERIOD_WIDTH-1 (saturation sets overflow).
REQ-022 On each subsequent rise, the period counter value SHALL be captured into a period register and the counter reloaded to 1, so the captured value equals the cycle distance between consecutive rises.
REQ-023 Fewer than 2 rises in a gate SHALL yield period_cycles = 0.
REQ-024 In DONE (exactly one cycle): edge_count, period_cycles and overflow SHALL load from internal state, and valid SHALL be 1. Next state SHALL be GATE (counters cleared as in REQ-018) if CONTINUOUS=1, else IDLE.
REQ-025 start SHALL be ignored in GATE and DONE; it is not queued.
REQ-026 Outputs SHALL hold their values between valid pulses. valid SHALL be 1 only in DONE.
REQ-027 Latency: valid SHALL assert exactly GATE_CYCLES+1 clk_in cycles after the cycle start is sampled in IDLE.
REQ-028 sig_in above FREC_IN/4 is out of range; behaviour is bounded (saturating counters, no lockup) but values are unspecified.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, all counters and synchronizer flops to 0, and busy, valid, edge_count, period_cycles and overflow to 0, regardless of state.
REQ-030 After reset is released, the block SHALL remain in IDLE until start=1, including when CONTINUOUS=1.
REQ-031 Reset asserted mid-GATE SHALL discard the partial measurement; no valid pulse is produced.

Verification (FREC_IN=100.0, GATE_US=10 -> GATE_CYCLES=1000 unless noted)
REQ-032 sig_in low, start pulse, first rise 5 cycles later, then period 20 cycles -> valid 1001 cycles after start, edge_count=50, period_cycles=20, overflow=0.
REQ-033 sig_in held constant, start pulse -> valid after 1001 cycles, edge_count=0, period_cycles=0, overflow=0.
REQ-034 Same stimulus as REQ-032 with COUNT_WIDTH=4 -> edge_count=15, overflow=1, period_cycles=20.
REQ-035 reset=0 at cycle 500 of the gate, released, then start again -> no valid for the aborted gate, all outputs 0; second gate reports normally.
REQ-036 CONTINUOUS=1, single start, period 20 -> valid every 1001 cycles with stable results; start pulses during busy have no effect.
